// File: rtl/vector_beat_sequencer_pkg.sv
// Shared types and defaults for the vector beat sequencer.
package vseq_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, MEM_WAIT} vseq_state_t;

  localparam int VSEQ_VLEN_DEF  = 8;
  localparam int VSEQ_LANES_DEF = 2;
  localparam int ALUOP_W        = 4;

  // Per-instruction flags captured at issue.
  typedef struct packed {
    logic vec;
    logic rd;
    logic wr;
    logic wb;
  } vseq_flags_t;
endpackage

// File: rtl/vector_beat_sequencer_if.sv
// Decode/datapath-side bundle of the beat sequencer: issue handshake, memory ack, beat outputs.
interface vector_beat_sequencer_if
  import vseq_pkg::*;
#(
  parameter int VLEN = VSEQ_VLEN_DEF
);
  localparam int IDX_W = $clog2(VLEN);

  logic               issue_valid;
  logic               issue_ready;
  logic               vector_op;
  logic               mem_read;
  logic               mem_write;
  logic               reg_write;
  logic [ALUOP_W-1:0] alu_op_in;
  logic               mem_ack;
  logic [ALUOP_W-1:0] alu_op_out;
  logic               beat_valid;
  logic [IDX_W-1:0]   beat_idx;
  logic               beat_mem_req;
  logic               beat_wb_en;
  logic               stall;
  logic               done;

  modport master (
    output issue_valid, vector_op, mem_read, mem_write, reg_write, alu_op_in, mem_ack,
    input  issue_ready, alu_op_out, beat_valid, beat_idx, beat_mem_req, beat_wb_en, stall, done
  );

  modport slave (
    input  issue_valid, vector_op, mem_read, mem_write, reg_write, alu_op_in, mem_ack,
    output issue_ready, alu_op_out, beat_valid, beat_idx, beat_mem_req, beat_wb_en, stall, done
  );
endinterface

// File: rtl/vector_beat_sequencer_perf_counter.sv
// Saturating 32-bit event counter; only built when VSEQ_PERF_EN is defined.
`ifdef VSEQ_PERF_EN
module vseq_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);
  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 32'hFFFF_FFFF)) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;
endmodule
`endif

// File: rtl/vector_beat_sequencer.sv
// Execute-stage sequencer: splits one decoded instruction into LANES-wide beats.
// Optional VSEQ_PERF_EN adds the busy_cycles stall counter port.
module vector_beat_sequencer
  import vseq_pkg::*;
#(
  parameter int VLEN  = VSEQ_VLEN_DEF,
  parameter int LANES = VSEQ_LANES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  vector_beat_sequencer_if.slave  bus
`ifdef VSEQ_PERF_EN
  ,
  output logic [31:0]             busy_cycles
`endif
);
  localparam int IDX_W = $clog2(VLEN);

  if (VLEN % LANES != 0) begin : g_bad_cfg
    $error("vector_beat_sequencer: VLEN must be a multiple of LANES");
  end

  vseq_state_t        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  vseq_flags_t        flg_q, flg_d;

  logic is_mem, last_beat, in_beat, retire;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    aluop_d   = aluop_q;
    flg_d     = flg_q;
    retire    = 1'b0;
    is_mem    = flg_q.rd | flg_q.wr;
    last_beat = !flg_q.vec || (idx_q == IDX_W'(VLEN - LANES));
    in_beat   = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (bus.issue_valid) begin
          state_d = EXEC;
          idx_d   = '0;
          aluop_d = bus.alu_op_in;
          flg_d   = '{vec: bus.vector_op, rd: bus.mem_read, wr: bus.mem_write, wb: bus.reg_write};
        end
      end
      EXEC: begin
        if (!is_mem || bus.mem_ack) retire = 1'b1;
        else                        state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (bus.mem_ack) retire = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Retiring the final beat also parks beat_idx back at 0 for the next op.
    if (retire) begin
      if (last_beat) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        state_d = EXEC;
        idx_d   = idx_q + IDX_W'(LANES);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      aluop_q <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      aluop_q <= aluop_d;
      flg_q   <= flg_d;
    end
  end

  // Read+write together behaves as a load; pure stores never write back.
  assign bus.issue_ready  = (state_q == IDLE);
  assign bus.stall        = in_beat;
  assign bus.beat_valid   = in_beat;
  assign bus.beat_idx     = idx_q;
  assign bus.alu_op_out   = aluop_q;
  assign bus.beat_mem_req = in_beat && is_mem;
  assign bus.beat_wb_en   = retire && flg_q.wb && (!is_mem || flg_q.rd);
  assign bus.done         = retire && last_beat;

`ifdef VSEQ_PERF_EN
  vseq_perf_counter u_perf (
    .clk   (clk),
    .rst   (rst),
    .inc   (in_beat),
    .count (busy_cycles)
  );
`endif
endmodule

// File: tb/tb_vector_beat_sequencer.sv
// Directed + randomized bench for vector_beat_sequencer against a per-beat reference model.
module tb_vector_beat_sequencer;
  import vseq_pkg::*;

  localparam int VLEN  = 8;
  localparam int LANES = 2;
  localparam int NB    = VLEN / LANES;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   busy_model = 0;

  vector_beat_sequencer_if #(.VLEN(VLEN)) bus ();

`ifdef VSEQ_PERF_EN
  logic [31:0] busy_cycles;
`endif

  vector_beat_sequencer #(.VLEN(VLEN), .LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef VSEQ_PERF_EN
    ,
    .busy_cycles (busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "/ready"}, 32'(bus.issue_ready),  32'd1);
    chk({tag, "/stall"}, 32'(bus.stall),        32'd0);
    chk({tag, "/valid"}, 32'(bus.beat_valid),   32'd0);
    chk({tag, "/mreq"},  32'(bus.beat_mem_req), 32'd0);
    chk({tag, "/wb"},    32'(bus.beat_wb_en),   32'd0);
    chk({tag, "/done"},  32'(bus.done),         32'd0);
  endtask

  // Model: nb beats, beat b at element b*LANES; a memory beat lasts 1+dly[b] cycles and
  // retires on the ack cycle; a non-memory beat retires in one cycle. Called at a negedge
  // of an IDLE cycle; returns at the negedge of the bubble cycle after done.
  task automatic run_instr(input string tag, input bit vec, input bit rd, input bit wr,
                           input bit wb, input logic [3:0] op, input int dly[NB]);
    int  nb;
    bit  mem;
    nb  = vec ? NB : 1;
    mem = rd | wr;
    #1;
    bus.issue_valid = 1'b1; bus.vector_op = vec; bus.mem_read = rd;
    bus.mem_write = wr;     bus.reg_write = wb;  bus.alu_op_in = op;
    chk({tag, "/accept_ready"}, 32'(bus.issue_ready), 32'd1);
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      int d;
      d = mem ? dly[b] : 0;
      for (int c = 0; c <= d; c++) begin
        bit fin;
        fin = (c == d);
        // Noise that must be ignored: foreign issue attempts, acks on ALU beats.
        bus.mem_ack     = mem ? fin : 1'($urandom);
        bus.issue_valid = 1'($urandom);
        bus.alu_op_in   = 4'($urandom);
        bus.vector_op   = 1'($urandom);
        @(negedge clk);
        chk({tag, "/valid"}, 32'(bus.beat_valid),   32'd1);
        chk({tag, "/idx"},   32'(bus.beat_idx),     32'(b * LANES));
        chk({tag, "/mreq"},  32'(bus.beat_mem_req), 32'(mem));
        chk({tag, "/wb"},    32'(bus.beat_wb_en),   32'(fin && wb && (!mem || rd)));
        chk({tag, "/done"},  32'(bus.done),         32'(fin && (b == nb - 1)));
        chk({tag, "/stall"}, 32'(bus.stall),        32'd1);
        chk({tag, "/ready"}, 32'(bus.issue_ready),  32'd0);
        chk({tag, "/aluop"}, 32'(bus.alu_op_out),   32'(op));
        busy_model++;
        @(posedge clk); #1;
      end
    end
    bus.issue_valid = 1'b0;
    bus.mem_ack     = 1'($urandom);
    @(negedge clk);
    check_idle({tag, "/bubble"});
    chk({tag, "/bubble_aluop"}, 32'(bus.alu_op_out), 32'(op));
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    int dly[NB];
    bus.issue_valid = 1'b0; bus.vector_op = 1'b0; bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;   bus.reg_write = 1'b0; bus.alu_op_in = '0;
    bus.mem_ack = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_idle("reset");
    chk("reset/idx",   32'(bus.beat_idx),   32'd0);
    chk("reset/aluop", 32'(bus.alu_op_out), 32'd0);
    rst = 1'b1;

    // mem_ack while idle changes nothing
    bus.mem_ack = 1'b1;
    @(negedge clk);
    check_idle("idle_ack");
    @(negedge clk);
    check_idle("idle_ack2");
    chk("idle_ack/aluop", 32'(bus.alu_op_out), 32'd0);
    bus.mem_ack = 1'b0;

    dly = '{0, 0, 0, 0};
    run_instr("scalar_add", 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, dly);
    run_instr("vector_add", 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, dly);
    dly = '{2, 2, 2, 2};
    run_instr("vector_load", 1'b1, 1'b1, 1'b0, 1'b1, 4'b0011, dly);
    dly = '{0, 0, 0, 0};
    run_instr("vector_store", 1'b1, 1'b0, 1'b1, 1'b1, 4'b0101, dly);
    dly = '{1, 0, 3, 0};
    run_instr("rdwr_as_load", 1'b1, 1'b1, 1'b1, 1'b1, 4'b1001, dly);
    dly = '{3, 0, 0, 0};
    run_instr("scalar_load", 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, dly);

    // Reset asserted during beat_idx 4 of a vector op
    #1;
    bus.issue_valid = 1'b1; bus.vector_op = 1'b1; bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;   bus.reg_write = 1'b1; bus.alu_op_in = 4'b1010;
    @(posedge clk); #1;
    bus.issue_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("midrst/idx_before", 32'(bus.beat_idx), 32'd4);
    rst = 1'b0;
    #1;
    check_idle("midrst");
    chk("midrst/idx",   32'(bus.beat_idx),   32'd0);
    chk("midrst/aluop", 32'(bus.alu_op_out), 32'd0);
    busy_model = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("after_rst");

    // Randomized instructions
    for (int n = 0; n < 40; n++) begin
      for (int b = 0; b < NB; b++) dly[b] = int'($urandom_range(0, 3));
      run_instr($sformatf("rand%0d", n), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 4'($urandom), dly);
    end

`ifdef VSEQ_PERF_EN
    chk("busy_cycles", busy_cycles, 32'(busy_model));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
